// File: rtl/instr_fetch_queue.sv
// Instruction buffer between F and D: a circular FIFO of fetched words and their PCs.
// The head entry is presented pre-split into MIPS fields, plus eret detection and serialisation.
module instr_fetch_queue #(
   parameter int          DEPTH      = 4,
   parameter int          PC_W       = 32,
   parameter int          ERET_BLOCK = 1,
   parameter logic [31:0] ERET_WORD  = 32'h42000018
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [31:0]              in_instr,
   input  logic [PC_W-1:0]          in_pc,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_instr,
   output logic [PC_W-1:0]          out_pc,
   output logic [5:0]               op,
   output logic [4:0]               rsad,
   output logic [4:0]               rtad,
   output logic [4:0]               rdad,
   output logic [4:0]               shamt,
   output logic [5:0]               func,
   output logic [15:0]              imm16,
   output logic [25:0]              imm26,
   output logic [4:0]               b_func,
   output logic                     eret,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     eret_pending
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic          BLK  = (ERET_BLOCK != 0);

   typedef struct packed {
      logic [31:0]     instr;
      logic [PC_W-1:0] pc;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          head;
   logic [AW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   eret_cnt;
   logic            push, pop, push_eret, pop_eret;

   assign out_valid    = (count != '0);
   assign eret_pending = (eret_cnt != '0);
   assign in_ready     = (count < FULL) & ~(BLK & eret_pending) & ~flush;

   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign push_eret = push & (in_instr == ERET_WORD);
   assign pop_eret  = pop & eret;

   // Empty queue presents an all-zero word, which decodes as a nop.
   always_comb begin
      head = '0;
      if (out_valid)
         head = mem[rd_ptr];
   end

   assign out_instr = head.instr;
   assign out_pc    = head.pc;
   assign op        = head.instr[31:26];
   assign rsad      = head.instr[25:21];
   assign rtad      = head.instr[20:16];
   assign rdad      = head.instr[15:11];
   assign shamt     = head.instr[10:6];
   assign func      = head.instr[5:0];
   assign imm16     = head.instr[15:0];
   assign imm26     = head.instr[25:0];
   assign b_func    = head.instr[20:16];
   assign eret      = out_valid & (head.instr == ERET_WORD);

   // Storage is never cleared; reset and flush only rewind the pointers.
   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wr_ptr] <= '{instr: in_instr, pc: in_pc};
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         eret_cnt <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         case ({push_eret, pop_eret})
            2'b10:   eret_cnt <= eret_cnt + CW'(1);
            2'b01:   eret_cnt <= eret_cnt - CW'(1);
            default: eret_cnt <= eret_cnt;
         endcase
      end
   end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Parametrised instruction buffer between the F and D stages of the P7 pipeline.
- Accepts fetched words with their PC over a valid/ready handshake and stores them in a circular FIFO of DEPTH entries.
- Presents the head entry already split into MIPS fields (op, func, rs, rt, rd, shamt, imm16, imm26, b_func), plus an eret flag.
- Supports a flush for exceptions and branches, and optional serialisation behind eret.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- PC_W, 32, width of the stored PC.
- ERET_BLOCK, 1, if 1, no further word is accepted while an eret sits in the queue.
- ERET_WORD, 32'h42000018, encoding that marks eret.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  drop all entries this cycle.
- in_valid  in  1  fetch presents a word.
- in_ready  out  1  queue can accept a word this cycle.
- in_instr  in  32  fetched instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry is valid.
- out_ready  in  1  D stage consumes the head entry.
- out_instr  out  32  raw head instruction.
- out_pc  out  PC_W  head PC.
- op  out  6  head[31:26].
- rsad  out  5  head[25:21].
- rtad  out  5  head[20:16].
- rdad  out  5  head[15:11].
- shamt  out  5  head[10:6].
- func  out  6  head[5:0].
- imm16  out  16  head[15:0].
- imm26  out  26  head[25:0].
- b_func  out  5  head[20:16], the REGIMM selector.
- eret  out  1  head equals ERET_WORD.
- count  out  clog2(DEPTH)+1  number of valid entries.
- eret_pending  out  1  an eret entry is in the queue.

Behaviour:
- Storage: DEPTH×(32+PC_W) array, with read pointer rd_ptr, write pointer wr_ptr and count.
  - Pointers wrap modulo DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count < DEPTH) & ~(ERET_BLOCK & eret_pending) & ~flush.
  - Combinational from registered state and flush only; it does not depend on out_ready.
  - When full, a simultaneous pop does not allow a push.
- out_valid = (count != 0).
- Head outputs are combinational slices of the entry at rd_ptr, so a pushed word first appears at the outputs in the next cycle (latency 1).
- When out_valid = 0:
  - out_instr, out_pc and all field outputs are 0; eret = 0.
  - out_instr = 0 decodes as sll $0,$0,0 (nop).
- Count update:
  - push only: count+1.
  - pop only: count-1.
  - both push and pop: unchanged, and both pointers advance.
- eret_pending is held as an internal counter of eret entries in the queue.
  - Increments on a push of ERET_WORD.
  - Decrements on a pop with eret = 1.
  - Both events in the same cycle: unchanged.
  - eret_pending = (counter != 0).
- Flush has priority over everything:
  - In the flush cycle, no push happens even if in_valid = 1.
  - The pop is ignored.
  - Next cycle: count = 0, both pointers = 0, eret counter = 0.
  - Stored data is not cleared.
- Reset (synchronous, beats flush): identical effect to flush.
  - After reset: out_valid = 0, in_ready = 1, count = 0, eret_pending = 0, and every field output is 0.
  - Reset asserted mid-stream discards all entries regardless of in_valid and out_ready.
- No error is flagged for push when full or pop when empty; those events are masked by in_ready and out_valid.
- All field outputs are taken from the raw word without sign-extension.

Test Plan:
- Reset, then push 0x8C220004 at pc 0x3000, with out_ready = 0.
  - Next cycle: out_valid = 1, op = 0x23, rsad = 1, rtad = 2, imm16 = 0x0004, out_pc = 0x3000, count = 1.
- Push 5 words back-to-back with out_ready = 0 and DEPTH = 4.
  - in_ready drops after the 4th push; the 5th word is held off.
  - Popping then returns words 1–4 in order, with correct pcs.
- With count = 2, hold in_valid = 1 and out_ready = 1 for 6 cycles.
  - count stays 2 and pointers wrap.
  - Output order equals input order: 0x3000, 0x3004, ….
- Push 0x42000018, then 0x00000000, with ERET_BLOCK = 1.
  - eret_pending = 1 and in_ready = 0 after the first push.
  - When the eret is popped (eret = 1), in_ready returns to 1 the next cycle.
- With 3 entries held, assert flush together with in_valid = 1 and out_ready = 1.
  - Next cycle: count = 0, out_valid = 0, and the flushed-cycle word is not stored.
- Push 0x04110010 (bgezal).
  - b_func = 0x11, op = 0x01, imm16 = 0x0010.
- Assert reset while full.
  - Next cycle: count = 0, in_ready = 1, all fields 0.
